piso_tx: RTL

Serial frame transmitter: accepts a parallel word on a one-cycle start strobe and shifts it out on a single line as a framed bitstream (start bit, data LSB-first, stop bit), each bit held for a programmable number of clocks. It is the driving end of the serial line sampled by the team's flip-flop/shift-register receivers in the sequential-logic lab set. Its output is registered, so it can feed a D flip-flop input directly.

---
 rtl/piso_tx.sv | 106 ++++++++++
 1 files changed

// File: rtl/piso_tx.sv
// piso_tx: framed serial transmitter (start bit, LSB-first data, stop bit).
// Q is registered and idles high; every bit is held for CLKS_PER_BIT clocks.
module piso_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Data,
    output logic             Q,
    output logic             Busy,
    output logic             Done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int NW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] BIT_LAST  = NW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shift_nxt;
    logic [NW-1:0]    bit_cnt;
    logic [BW-1:0]    baud_cnt;
    logic             baud_end;

    assign baud_end  = (baud_cnt == BAUD_LAST);
    assign shift_nxt = shreg >> 1;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            Q        <= 1'b1;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    Q    <= 1'b1;
                    Busy <= 1'b0;
                    if (Start) begin
                        shreg    <= Data;
                        state    <= START;
                        Q        <= 1'b0;
                        Busy     <= 1'b1;
                        baud_cnt <= '0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= DATA;
                        Q        <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state <= STOP;
                            Q     <= 1'b1;
                        end else begin
                            shreg   <= shift_nxt;
                            bit_cnt <= bit_cnt + NW'(1);
                            Q       <= shift_nxt[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    Q     <= 1'b1;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
